// File: rtl/display_pkg.sv
// Shared definitions for the button-driven display counter: digit width,
// default count limit and the debounce FSM state type.
package display_pkg;

  localparam int DIGIT_W           = 4;
  localparam int DEFAULT_MAX_COUNT = 7;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_counter_debounce.sv
// debounce: 2-flop synchronizer, press/release debounce FSM and a registered
// single-cycle press pulse for one raw pushbutton.
module debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          synced;
  db_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          done;
  logic          press_next;

  // Two-stage synchronizer for the asynchronous button level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn};
  end

  assign synced = sync_q[1];

  // Saturating increment; done means this cycle is the last required stable one.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign done    = (cnt_inc == CNT_MAX);

  // State, stability counter and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      press <= press_next;
    end
  end

  // Next-state logic; the pulse fires only when a press is freshly qualified,
  // so a bounce during release that returns to PRESSED does not re-count.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (synced) begin
          if (done) begin
            state_next = PRESSED;
            press_next = 1'b1;
          end else begin
            state_next = WAIT_PRESS;
            cnt_next   = cnt_inc;
          end
        end
      end
      WAIT_PRESS: begin
        if (!synced) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (done) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        cnt_next = '0;
        if (!synced) begin
          if (done) begin
            state_next = IDLE;
          end else begin
            state_next = WAIT_RELEASE;
            cnt_next   = cnt_inc;
          end
        end
      end
      WAIT_RELEASE: begin
        if (synced) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (done) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_counter.sv
// btn_counter: up/down pushbutton counter with wrap pulse and synchronous clear.
// Optional feature: define AUTO_COUNT_EN to add the auto_en port and a
// TICK_DIV-cycle prescaler whose ticks act as extra up presses.
module btn_counter
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_COUNT       = DEFAULT_MAX_COUNT,
  parameter int TICK_DIV        = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               clr,
`ifdef AUTO_COUNT_EN
  input  logic               auto_en,
`endif
  output logic [DIGIT_W-1:0] counter,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] MAX_C = DIGIT_W'(MAX_COUNT);

  // An out-of-range configuration shows up as this block in the elaborated
  // hierarchy, which makes it easy to spot in a netlist review.
  if (MAX_COUNT < 1 || MAX_COUNT > 15 || TICK_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_illegal_params
  end

  logic up_press, down_press;
  logic tick;
  logic up_p, down_p;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (up_press)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .press (down_press)
  );

`ifdef AUTO_COUNT_EN
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = auto_en && (presc == PRESC_LAST);

  // Prescaler: free-runs while enabled, restarts on disable or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                presc <= '0;
    else if (!auto_en || clr)  presc <= '0;
    else if (tick)             presc <= '0;
    else                       presc <= presc + PW'(1);
  end
`else
  assign tick = 1'b0;
`endif

  assign up_p   = up_press | tick;
  assign down_p = down_press;

  // Count register: clear wins, simultaneous up/down cancel, wrap at the ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        counter <= '0;
      end else if (up_p && !down_p) begin
        if (counter >= MAX_C) begin
          counter <= '0;
          wrap    <= 1'b1;
        end else begin
          counter <= counter + DIGIT_W'(1);
        end
      end else if (down_p && !up_p) begin
        if (counter == '0) begin
          counter <= MAX_C;
          wrap    <= 1'b1;
        end else begin
          counter <= counter - DIGIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_counter.sv
// Directed bench for btn_counter (DEBOUNCE_CYCLES=4, MAX_COUNT=7, TICK_DIV=10).
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_btn_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       clr;
`ifdef AUTO_COUNT_EN
  logic       auto_en;
`endif
  logic [3:0] counter;
  logic       wrap;

  int vectors     = 0;
  int miscompares = 0;
  int wrap_seen   = 0;
  int wrap_mark;

  always #5 clk = ~clk;

  btn_counter #(
    .DEBOUNCE_CYCLES (4),
    .MAX_COUNT       (7),
    .TICK_DIV        (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .clr      (clr),
`ifdef AUTO_COUNT_EN
    .auto_en  (auto_en),
`endif
    .counter  (counter),
    .wrap     (wrap)
  );

  // Count wrap-high cycles, sampled once per cycle away from the rising edge.
  always @(negedge clk) if (wrap === 1'b1) wrap_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    clr      = 1'b0;
`ifdef AUTO_COUNT_EN
    auto_en  = 1'b0;
`endif
    cycles(3);
    check("reset_counter", 32'(counter), 0);
    check("reset_wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    cycles(2);

    // Glitch of 3 cycles never qualifies (needs 4 stable synced cycles).
    wrap_mark = wrap_seen;
    btn_up = 1'b1;
    cycles(3);
    btn_up = 1'b0;
    cycles(12);
    check("glitch_counter", 32'(counter), 0);
    check("glitch_wrap", 32'(wrap_seen - wrap_mark), 0);

    // Held press: update lands exactly 7 rising edges after the rise.
    btn_up = 1'b1;
    cycles(6);
    check("latency_before", 32'(counter), 0);
    cycles(1);
    check("latency_at7", 32'(counter), 1);
    cycles(13);
    btn_up = 1'b0;
    cycles(10);
    check("hold_single_inc", 32'(counter), 1);

    // Clear back to 0, then eight qualified up presses.
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("clr_to_zero", 32'(counter), 0);
    wrap_mark = wrap_seen;
    for (int i = 1; i <= 8; i++) begin
      btn_up = 1'b1;
      cycles(7);
      check($sformatf("up_seq_%0d", i), 32'(counter), 32'(i % 8));
      check($sformatf("up_wrap_%0d", i), 32'(wrap), (i == 8) ? 1 : 0);
      cycles(3);
      btn_up = 1'b0;
      cycles(10);
    end
    check("up_seq_wrap_count", 32'(wrap_seen - wrap_mark), 1);

    // Down at 0 wraps to MAX with a single-cycle wrap pulse.
    btn_down = 1'b1;
    cycles(7);
    check("down_wrap_counter", 32'(counter), 7);
    check("down_wrap_pulse", 32'(wrap), 1);
    cycles(1);
    check("down_wrap_one_cycle", 32'(wrap), 0);
    cycles(2);
    btn_down = 1'b0;
    cycles(10);

    // Both buttons qualify in the same cycle: no change, no wrap.
    btn_up   = 1'b1;
    btn_down = 1'b1;
    cycles(7);
    check("both_counter", 32'(counter), 7);
    check("both_wrap", 32'(wrap), 0);
    cycles(3);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    cycles(10);

    // Two plain decrements: 7 -> 6 -> 5.
    for (int i = 0; i < 2; i++) begin
      btn_down = 1'b1;
      cycles(10);
      btn_down = 1'b0;
      cycles(10);
    end
    check("down_to_5", 32'(counter), 5);

    // clr coincident with an up pulse at 5 wins and suppresses wrap.
    btn_up = 1'b1;
    cycles(6);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("clr_prio_counter", 32'(counter), 0);
    check("clr_prio_wrap", 32'(wrap), 0);
    cycles(3);
    btn_up = 1'b0;
    cycles(10);
    check("clr_prio_no_late_inc", 32'(counter), 0);

    // One press to 1, then reset during WAIT_PRESS discards the pending press.
    btn_up = 1'b1;
    cycles(10);
    btn_up = 1'b0;
    cycles(10);
    check("pre_reset_counter", 32'(counter), 1);
    btn_up = 1'b1;
    cycles(4);
    rst_n = 1'b0;
    cycles(2);
    check("mid_reset_counter", 32'(counter), 0);
    check("mid_reset_wrap", 32'(wrap), 0);
    btn_up = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(12);
    check("post_reset_no_pulse", 32'(counter), 0);

`ifdef AUTO_COUNT_EN
    // Prescaler ticks at edges 10, 20, 30 of a 35-cycle enable window.
    auto_en = 1'b1;
    cycles(9);
    check("auto_before_tick", 32'(counter), 0);
    cycles(1);
    check("auto_first_tick", 32'(counter), 1);
    cycles(25);
    auto_en = 1'b0;
    check("auto_35_cycles", 32'(counter), 3);
    cycles(20);
    check("auto_frozen", 32'(counter), 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
